// File: rtl/sa_pkg.sv
// Shared types and constants for the 4x4 systolic input-skew feeder.
package sa_pkg;

  localparam int DW     = 32;
  localparam int N      = 4;
  // Beat index 0..N-1 and stream step 0..2N-2 counter widths.
  localparam int KW     = $clog2(N);
  localparam int TW     = $clog2(2 * N - 1);
  localparam int T_LAST = 2 * N - 2;

  typedef logic [DW-1:0] word_t;
  typedef word_t [0:N-1] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feed_state_t;

endpackage

// File: rtl/sa_operand_buf.sv
// 4x4 operand register file. Beat k writes mem[lane][k] for every lane;
// for A that is column k, for B (row k arrives per beat) that stores B
// transposed, so both operands read back as mem[lane][step - lane].
module sa_operand_buf
  import sa_pkg::*;
(
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [KW-1:0] wr_idx_i,
  input  lane_vec_t     wr_data_i,
  input  logic [TW-1:0] step_i,
  output lane_vec_t     rd_data_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  word_t mem_q [N][N];

  logic [TW-1:0] diff;

  // Column write: one element per lane at position wr_idx_i.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int lane = 0; lane < N; lane++) begin
        mem_q[lane][wr_idx_i] <= wr_data_i[lane];
      end
    end
  end

  // Skewed read: lane i returns element [i][step-i], zero outside 0..N-1.
  always_comb begin
    rd_data_o = '0;
    diff      = '0;
    for (int lane = 0; lane < N; lane++) begin
      diff = step_i - TW'(lane);
      if ((step_i >= TW'(lane)) && (diff <= TW'(N - 1))) begin
        rd_data_o[lane] = mem_q[lane][diff[KW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sa_feeder_4x4.sv
// Input-skew feeder: loads a 4x4 A/B operand pair in four valid/ready beats,
// replays them diagonally skewed into the tile, holds ARR_EN through a zero
// drain window, then pulses DONE for one cycle.
//
// Handshake: a beat transfers on a rising edge where in_valid_i and
// in_ready_o are both high. in_ready_o depends on state only (IDLE/LOAD),
// never on in_valid_i, and is low while reset is asserted.
module sa_feeder_4x4
  import sa_pkg::*;
#(
  parameter int DRAIN_CYC = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  lane_vec_t   in_a_i,
  input  lane_vec_t   in_b_i,
  output lane_vec_t   row_y_o,
  output lane_vec_t   col_y_o,
  output logic        arr_en_o,
  output logic        busy_o,
  output logic        done_o,
  output feed_state_t state_o
);

  localparam int unsigned D_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
  localparam int          DCW    = (D_LAST > 0) ? $clog2(D_LAST + 1) : 1;

  feed_state_t    state_q;
  logic [KW-1:0]  k_q;
  logic [TW-1:0]  t_q;
  logic [DCW-1:0] d_q;
  logic           ready_q;
  logic           arr_en_q;
  logic           done_q;
  lane_vec_t      row_q;
  lane_vec_t      col_q;

  logic           accept;
  logic [TW-1:0]  rd_step;
  lane_vec_t      rd_a;
  lane_vec_t      rd_b;

  assign accept     = in_valid_i & ready_q;
  assign in_ready_o = ready_q;
  assign busy_o     = (state_q != IDLE);
  assign arr_en_o   = arr_en_q;
  assign done_o     = done_q;
  assign row_y_o    = row_q;
  assign col_y_o    = col_q;
  assign state_o    = state_q;

  // Read address is the step being entered on the next edge:
  // 0 when leaving LOAD, t+1 while streaming.
  always_comb begin
    rd_step = '0;
    if (state_q == STREAM) begin
      rd_step = t_q + TW'(1);
    end
  end

  sa_operand_buf u_buf_a (
    .clk_i     (clk_i),
    .wr_en_i   (accept),
    .wr_idx_i  (k_q),
    .wr_data_i (in_a_i),
    .step_i    (rd_step),
    .rd_data_o (rd_a)
  );

  sa_operand_buf u_buf_b (
    .clk_i     (clk_i),
    .wr_en_i   (accept),
    .wr_idx_i  (k_q),
    .wr_data_i (in_b_i),
    .step_i    (rd_step),
    .rd_data_o (rd_b)
  );

  // Load/stream/drain sequencer with registered tile-facing outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      k_q      <= '0;
      t_q      <= '0;
      d_q      <= '0;
      ready_q  <= 1'b0;
      arr_en_q <= 1'b0;
      done_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            k_q     <= KW'(1);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            k_q <= k_q + KW'(1);
            if (k_q == KW'(N - 1)) begin
              state_q  <= STREAM;
              t_q      <= '0;
              ready_q  <= 1'b0;
              arr_en_q <= 1'b1;
              row_q    <= rd_a;
              col_q    <= rd_b;
            end
          end
        end
        STREAM: begin
          if (t_q == TW'(T_LAST)) begin
            t_q   <= '0;
            row_q <= '0;
            col_q <= '0;
            if (DRAIN_CYC == 0) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              arr_en_q <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              d_q     <= '0;
            end
          end else begin
            t_q   <= t_q + TW'(1);
            row_q <= rd_a;
            col_q <= rd_b;
          end
        end
        DRAIN: begin
          if (d_q == DCW'(D_LAST)) begin
            d_q      <= '0;
            state_q  <= IDLE;
            done_q   <= 1'b1;
            arr_en_q <= 1'b0;
            ready_q  <= 1'b1;
          end else begin
            d_q <= d_q + DCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_feeder_4x4.sv
// Bench for sa_feeder_4x4: a default-drain instance and a zero-drain instance,
// checked cycle by cycle against a matrix-level skew model.
module tb_sa_feeder_4x4;
  import sa_pkg::*;

  localparam int DRAIN = 7;
  localparam int VW    = 4 + 8 * DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld  = 1'b0;
  logic        vld0 = 1'b0;
  lane_vec_t   in_a = '0;
  lane_vec_t   in_b = '0;

  logic        rdy, en, busy, done;
  lane_vec_t   row, col;
  feed_state_t dbg_state;
  logic        rdy0, en0, busy0, done0;
  lane_vec_t   row0, col0;
  feed_state_t dbg_state0;

  sa_feeder_4x4 #(.DRAIN_CYC(DRAIN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_ready_o(rdy),
    .in_a_i(in_a), .in_b_i(in_b), .row_y_o(row), .col_y_o(col),
    .arr_en_o(en), .busy_o(busy), .done_o(done), .state_o(dbg_state)
  );

  sa_feeder_4x4 #(.DRAIN_CYC(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld0), .in_ready_o(rdy0),
    .in_a_i(in_a), .in_b_i(in_b), .row_y_o(row0), .col_y_o(col0),
    .arr_en_o(en0), .busy_o(busy0), .done_o(done0), .state_o(dbg_state0)
  );

  int n_vec = 0;
  int n_err = 0;

  word_t ma [N][N];
  word_t mb [N][N];
  word_t na [N][N];
  word_t nb [N][N];

  // Scoreboard: per-cycle {ready, busy, done, arr_en, row, col}.
  logic [VW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  task automatic build_expected(input int drain);
    lane_vec_t r, c, z;
    z = '0;
    exp_q.delete();
    for (int t = 0; t <= 2 * N - 2; t++) begin
      r = '0;
      c = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          r[i] = ma[i][t-i];
          c[i] = mb[t-i][i];
        end
      end
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, r, c});
    end
    for (int d = 0; d < drain; d++) exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, z, z});
    exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, z, z});
  endtask

  // ---------------- drivers ----------------
  task automatic randomize_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom();
        mb[i][j] = $urandom();
        na[i][j] = $urandom();
        nb[i][j] = $urandom();
      end
  endtask

  task automatic drive_beat(input int k, input bit sel);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      in_a[i] = ma[i][k];
      in_b[i] = mb[k][i];
    end
    vld  = !sel;
    vld0 = sel;
  endtask

  task automatic junk_inputs();
    for (int i = 0; i < N; i++) begin
      in_a[i] = $urandom();
      in_b[i] = $urandom();
    end
  endtask

  // Observe one tile's stream/drain/done window; optionally keep in_valid
  // high with junk, presenting the next tile's beat 0 in the DONE cycle.
  task automatic observe_tile(input int drain, input bit sel, input bit noisy, input string tag);
    logic [VW-1:0] obs, exp_v;
    int c;
    c = 0;
    build_expected(drain);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      obs   = sel ? {rdy0, busy0, done0, en0, row0, col0} : {rdy, busy, done, en, row, col};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h want %h", tag, c, obs, exp_v);
      end
      if (noisy) begin
        junk_inputs();
        if (exp_q.size() == 0) begin
          for (int i = 0; i < N; i++) begin
            in_a[i] = na[i][0];
            in_b[i] = nb[0][i];
          end
        end
        if (sel) vld0 = 1'b1; else vld = 1'b1;
      end else begin
        vld  = 1'b0;
        vld0 = 1'b0;
        junk_inputs();
      end
      c++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [VW-1:0] obs;
    @(negedge clk);
    obs = {rdy, busy, done, en, row, col};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      obs = {rdy, busy, done, en, row, col};
      n_vec++;
      if (obs !== {1'b1, {(VW-1){1'b0}}}) begin
        n_err++;
        $display("FAIL idle cycle %0d: got %h want ready only", c, obs);
      end
      junk_inputs();
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = word_t'(16 * i + j);
        mb[i][j] = word_t'(256 + 16 * i + j);
      end
    for (int k = 0; k < N; k++) drive_beat(k, 1'b0);
    observe_tile(DRAIN, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_gaps();
    logic [3:0] obs;
    int gaps[4] = '{0, 2, 0, 4};
    randomize_mats();
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        @(negedge clk);
        obs = {rdy, busy, done, en};
        n_vec++;
        if (obs !== 4'b1100 || row !== '0 || col !== '0) begin
          n_err++;
          $display("FAIL gap k%0d g%0d: got %b want 1100", k, g, obs);
        end
        vld = 1'b0;
        junk_inputs();
      end
      drive_beat(k, 1'b0);
    end
    observe_tile(DRAIN, 1'b0, 1'b0, "gaps");
  endtask

  task automatic test_back_to_back();
    randomize_mats();
    for (int k = 0; k < N; k++) drive_beat(k, 1'b0);
    observe_tile(DRAIN, 1'b0, 1'b1, "ignore_valid");
    ma = na;
    mb = nb;
    for (int k = 1; k < N; k++) drive_beat(k, 1'b0);
    observe_tile(DRAIN, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] obs, exp_v;
    randomize_mats();
    for (int k = 0; k < N; k++) drive_beat(k, 1'b0);
    build_expected(DRAIN);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      vld   = 1'b0;
      obs   = {rdy, busy, done, en, row, col};
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pre_reset t%0d: got %h want %h", t, obs, exp_v);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {rdy, busy, done, en, row, col};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      obs = {rdy, busy, done, en, row, col};
      n_vec++;
      if (obs !== {1'b1, {(VW-1){1'b0}}}) begin
        n_err++;
        $display("FAIL post_reset cycle %0d: got %h want ready only", c, obs);
      end
    end
    randomize_mats();
    for (int k = 0; k < N; k++) drive_beat(k, 1'b0);
    observe_tile(DRAIN, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_drain0();
    randomize_mats();
    for (int k = 0; k < N; k++) drive_beat(k, 1'b1);
    observe_tile(0, 1'b1, 1'b0, "drain0");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_drain0();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
